// File: rtl/sprite_frame_sequencer.sv
// Sprite frame sequencer: paints the background once, then per frame
// erases and redraws N_CH flat-colour rectangles, one pixel per cycle.
module sprite_frame_sequencer #(
  parameter int N_CH        = 4,
  parameter int SPR_W       = 5,
  parameter int SPR_H       = 5,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120,
  parameter int COL_W       = 9,
  parameter int ADDR_W      = 15,
  parameter int FRAME_TICKS = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH*8-1:0]       ch_x,
  input  logic [N_CH*7-1:0]       ch_y,
  input  logic [N_CH*COL_W-1:0]   ch_colour,
  output logic [ADDR_W-1:0]       bg_addr,
  input  logic [COL_W-1:0]        bg_q,
  output logic [7:0]              oX,
  output logic [6:0]              oY,
  output logic [COL_W-1:0]        oColour,
  output logic                    oPlot,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int KW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_LATCH,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic [7:0]              r_dx;
  logic [6:0]              r_dy;
  logic                    r_drain;
  logic [CW-1:0]           r_cnt;
  logic [N_CH-1:0]         r_sv_valid;
  logic [N_CH*8-1:0]       r_sv_x;
  logic [N_CH*7-1:0]       r_sv_y;
  logic [N_CH-1:0]         r_nw_valid;
  logic [N_CH*8-1:0]       r_nw_x;
  logic [N_CH*7-1:0]       r_nw_y;
  logic [N_CH*COL_W-1:0]   r_nw_col;
  logic                    r_use_bg;
  logic [COL_W-1:0]        r_col;
  logic [7:0]              r_ox;
  logic [6:0]              r_oy;
  logic                    r_plot;
  logic                    r_fdone;

  logic                    w_sel_valid;
  logic [7:0]              w_sel_x;
  logic [6:0]              w_sel_y;
  logic [COL_W-1:0]        w_sel_col;
  logic                    w_clr;
  logic                    w_spr;
  logic [7:0]              w_bx;
  logic [6:0]              w_by;
  logic [8:0]              w_px;
  logic [7:0]              w_py;
  logic                    w_clip;
  logic                    w_issue;
  logic                    w_xlast;
  logic                    w_ylast;
  logic                    w_klast;
  logic [ADDR_W-1:0]       w_addr;

  // Pick the current channel from the saved set (erase) or new set (draw)
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_col   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_k == KW'(i)) begin
        if (r_state == S_ERASE) begin
          w_sel_valid = r_sv_valid[i];
          w_sel_x     = r_sv_x[8*i +: 8];
          w_sel_y     = r_sv_y[7*i +: 7];
        end else begin
          w_sel_valid = r_nw_valid[i];
          w_sel_x     = r_nw_x[8*i +: 8];
          w_sel_y     = r_nw_y[7*i +: 7];
        end
        w_sel_col = r_nw_col[COL_W*i +: COL_W];
      end
    end
  end

  assign w_clr   = (r_state == S_CLEAR);
  assign w_spr   = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_bx    = w_clr ? 8'd0 : w_sel_x;
  assign w_by    = w_clr ? 7'd0 : w_sel_y;
  assign w_px    = {1'b0, w_bx} + {1'b0, r_dx};
  assign w_py    = {1'b0, w_by} + {1'b0, r_dy};
  assign w_clip  = (w_px >= 9'(SCR_W)) || (w_py >= 8'(SCR_H));
  assign w_issue = !r_drain && (w_clr || (w_spr && w_sel_valid));
  assign w_xlast = (r_dx == (w_clr ? 8'(SCR_W-1) : 8'(SPR_W-1)));
  assign w_ylast = (r_dy == (w_clr ? 7'(SCR_H-1) : 7'(SPR_H-1)));
  assign w_klast = (r_k == KW'(N_CH-1));
  assign w_addr  = ADDR_W'(w_py) * ADDR_W'(SCR_W) + ADDR_W'(w_px);

  assign bg_addr    = w_issue ? w_addr : '0;
  assign oX         = r_ox;
  assign oY         = r_oy;
  assign oPlot      = r_plot;
  assign frame_done = r_fdone;
  assign busy       = (r_state != S_IDLE) && (r_state != S_WAIT);
  // ROM data lands with the pixel, so background colour bypasses the register
  assign oColour    = r_use_bg ? bg_q : r_col;

  // Sequencer FSM, raster counters and registered pixel outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_drain    <= 1'b0;
      r_cnt      <= '0;
      r_sv_valid <= '0;
      r_sv_x     <= '0;
      r_sv_y     <= '0;
      r_nw_valid <= '0;
      r_nw_x     <= '0;
      r_nw_y     <= '0;
      r_nw_col   <= '0;
      r_use_bg   <= 1'b0;
      r_col      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_plot     <= 1'b0;
      r_fdone    <= 1'b0;
    end else begin
      r_plot   <= 1'b0;
      r_fdone  <= 1'b0;
      r_use_bg <= 1'b0;
      r_col    <= oColour;
      if (w_issue) begin
        r_ox   <= w_px[7:0];
        r_oy   <= w_py[6:0];
        r_plot <= !w_clip;
        if (r_state == S_DRAW) r_col <= w_sel_col;
        else r_use_bg <= 1'b1;
        if (w_xlast) begin
          r_dx <= '0;
          if (w_ylast) begin
            r_dy    <= '0;
            r_drain <= 1'b1;
          end else begin
            r_dy <= r_dy + 7'd1;
          end
        end else begin
          r_dx <= r_dx + 8'd1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLEAR;
            r_dx    <= '0;
            r_dy    <= '0;
            r_drain <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (r_drain) begin
            r_drain <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CW'(FRAME_TICKS-1)) r_state <= S_LATCH;
          else r_cnt <= r_cnt + 1'b1;
        end
        S_LATCH: begin
          r_nw_valid <= ch_valid;
          r_nw_x     <= ch_x;
          r_nw_y     <= ch_y;
          r_nw_col   <= ch_colour;
          r_k        <= '0;
          r_dx       <= '0;
          r_dy       <= '0;
          r_drain    <= 1'b0;
          r_state    <= S_ERASE;
        end
        S_ERASE, S_DRAW: begin
          if (r_drain || !w_sel_valid) begin
            r_drain <= 1'b0;
            if (w_klast) begin
              r_k <= '0;
              if (r_state == S_ERASE) begin
                r_state <= S_DRAW;
              end else begin
                r_sv_valid <= r_nw_valid;
                r_sv_x     <= r_nw_x;
                r_sv_y     <= r_nw_y;
                r_fdone    <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_WAIT;
              end
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
